delayed_branch_resolver: RTL
============================

// Module: delayed_branch_resolver
// PURPOSE
//  Consumer of the delayed-branch channel from the branch generation unit (BGU).
//  Carries each lane's delayed branch (goto word + condition) down two pipeline slots.
//  In Stage3 it tests the condition against N/V/Z and, if true, redirects the PC.
//  A redirect flushes younger work; the block then drains garbage fetches for DRAIN_CYCLES advances.
// PARAMETERS
//  PC_W          9   width of PC / redirect_pc
//  CNT_W         16  width of saturating taken-branch counter
//  DRAIN_CYCLES  2   advances to discard after a redirect (B latency)
// PORTS
//  clk              in   1      clock, rising edge
//  rst_n            in   1      asynchronous, active-low reset
//  advance          in   1      pipeline advance (fetch_next); 0 = stall, hold all state
//  N, V, Z          in   1 ea   Stage3 flags, valid when advance=1
//  p0_b_in          in   16     lane0 delayed goto word: [15:8]=8'h20, [7:0]=dest
//  p0_cond_in       in   3      lane0 condition (NV0 AL1 EQ2 NE3 LT4 LE5 GT6 GE7)
//  p0_valid_in      in   1      lane0 carries a delayed branch this slot
//  p1_b_in          in   16     lane1 goto word (lane1 younger than lane0)
//  p1_cond_in       in   3      lane1 condition
//  p1_valid_in      in   1      lane1 valid
//  redirect_valid   out  1      1-cycle pulse: load redirect_pc into PC
//  redirect_pc      out  PC_W   {0, dest[7:1], 0}; always even
//  redirect_ir0_inv out  1      dest[0]: lane0 of the fetched pair must not execute
//  flush_younger    out  1      1-cycle pulse with redirect_valid: kill S1/S2 of core pipe
//  draining         out  1      1 while discarding post-redirect fetches
//  taken_count      out  CNT_W  saturating count of taken delayed branches
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, slot valids 0, FSM=IDLE, counter 0.
//  - Entry accepted into S1 on a posedge with advance=1 only if valid_in=1, b_in[15:8]=8'h20,
//    and FSM=IDLE; otherwise the S1 valid bit is written 0.
//  - advance=1: S1->S2->S3 shift (dest, cond, valid per lane). advance=0: every slot,
//    FSM state and counter hold; redirect_valid/flush_younger forced 0.
//  - Eval (comb, S3): EQ=Z, NE=!Z, LT=N^V, LE=(N^V)|Z, GT=!(N^V)&!Z, GE=!(N^V), AL=1, NV=0.
//  - Fire when advance=1 and S3 lane valid & cond true. If lane0 and lane1 both fire,
//    lane0 wins; lane1 is squashed. Only one redirect per cycle.
//  - On fire (same cycle, combinational): redirect_valid=1, flush_younger=1,
//    redirect_pc/ir0_inv from winning dest.
//  - At that clock edge: S1/S2 valids cleared, FSM->DRAIN, drain counter=DRAIN_CYCLES.
//    taken_count += 1 unless saturated at all-ones.
//  - FSM: IDLE --fire--> DRAIN. DRAIN: draining=1; each advance decrements the drain counter
//    and discards the entering entry; 1->0 transition returns to IDLE. A fire is impossible
//    in DRAIN (slots empty).
//  - Latency: an entry accepted at edge k is evaluated in the cycle after edge k+2
//    (three advances total).
//  - Redirect target width: dest 8b zero-extended into PC_W; no wrap logic.
//  - Reset mid-drain or mid-stall: immediate return to reset state, no redirect emitted.
// TESTING
//  1. Reset low, toggle clk -> all outputs 0, taken_count=0; release -> IDLE, draining=0.
//  2. Lane0 b=16'h2011, cond=AL, 3 advances -> redirect_valid=1, redirect_pc=9'h010,
//     ir0_inv=1; draining=1 for the next 2 advances.
//  3. Lane0 cond=EQ dest 8'h40, Z=0 at eval -> no redirect; repeat with Z=1 ->
//     redirect_pc=9'h040, ir0_inv=0, taken_count=1.
//  4. Both lanes valid, lane0 LT (N=1,V=0) dest 8'h20, lane1 AL dest 8'h30 ->
//     one redirect to 9'h020; lane1 squashed; taken_count +1 only.
//  5. Entry in S2, advance=0 for 5 cycles -> no shift, no redirect; fires on the 2nd
//     advance after resume. Same for an entry with b_in[15:8]=8'h21 -> never fires.
//  6. CNT_W=2: 4 AL redirects -> taken_count stays 3. rst_n low during DRAIN ->
//     draining=0 immediately.

Source files
------------

// File: rtl/delayed_branch_resolver.sv
// delayed_branch_resolver
// Carries each lane's delayed branch down two pipeline slots and evaluates the
// branch condition against N/V/Z in Stage3. A taken branch redirects the PC and
// flushes the younger work. The block then discards DRAIN_CYCLES advances of
// wrong-path fetches.
//
// Handshake: there is no valid/ready back-pressure on the BGU channel. On a
// posedge with advance=1, S1 takes whatever the BGU presents; a lane is marked
// valid only when pX_valid_in=1, the goto opcode byte is 8'h20 and the block is
// IDLE. With advance=0 every slot, the FSM and the counter hold, and no
// redirect is emitted. redirect_valid and flush_younger are single-cycle pulses
// that are qualified by advance.
module delayed_branch_resolver #(
  parameter int PC_W         = 9,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             N,
  input  logic             V,
  input  logic             Z,
  input  logic [15:0]      p0_b_in,
  input  logic [2:0]       p0_cond_in,
  input  logic             p0_valid_in,
  input  logic [15:0]      p1_b_in,
  input  logic [2:0]       p1_cond_in,
  input  logic             p1_valid_in,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             redirect_ir0_inv,
  output logic             flush_younger,
  output logic             draining,
  output logic [CNT_W-1:0] taken_count
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  // Slot index 0 = S1, 1 = S2, 2 = S3; lane index 0 = lane0 (older).
  logic [2:0][1:0]      vld_q, vld_d;
  logic [2:0][1:0][7:0] dst_q, dst_d;
  logic [2:0][1:0][2:0] cnd_q, cnd_d;

  state_t               state_q, state_d;
  logic [DW-1:0]        drain_cnt_q, drain_cnt_d;
  logic                 draining_q, draining_d;
  logic [CNT_W-1:0]     taken_q, taken_d;

  logic [1:0]           lane_fire;
  logic                 fire;
  logic [7:0]           win_dest;
  logic                 acc0, acc1;

  // Condition codes: NV AL EQ NE LT LE GT GE.
  function automatic logic cond_true(input logic [2:0] c, input logic n,
                                     input logic v, input logic z);
    logic lt;
    lt = n ^ v;
    case (c)
      3'd0:    cond_true = 1'b0;
      3'd1:    cond_true = 1'b1;
      3'd2:    cond_true = z;
      3'd3:    cond_true = ~z;
      3'd4:    cond_true = lt;
      3'd5:    cond_true = lt | z;
      3'd6:    cond_true = ~lt & ~z;
      default: cond_true = ~lt;
    endcase
  endfunction

  // Stage3 evaluation and redirect outputs. Lane0 wins when both lanes fire.
  always_comb begin
    lane_fire[0] = advance & vld_q[2][0] & cond_true(cnd_q[2][0], N, V, Z);
    lane_fire[1] = advance & vld_q[2][1] & cond_true(cnd_q[2][1], N, V, Z);
    fire         = |lane_fire;
    win_dest     = lane_fire[0] ? dst_q[2][0] : dst_q[2][1];

    redirect_valid   = fire;
    flush_younger    = fire;
    redirect_ir0_inv = fire & win_dest[0];
    redirect_pc      = '0;
    if (fire) begin
      redirect_pc[7:0] = {win_dest[7:1], 1'b0};
    end
  end

  // Next-state for the slot shift register. A fire kills everything behind it.
  always_comb begin
    vld_d = vld_q;
    dst_d = dst_q;
    cnd_d = cnd_q;
    acc0  = (state_q == IDLE) & p0_valid_in & (p0_b_in[15:8] == 8'h20);
    acc1  = (state_q == IDLE) & p1_valid_in & (p1_b_in[15:8] == 8'h20);
    if (advance) begin
      vld_d[2] = vld_q[1];
      dst_d[2] = dst_q[1];
      cnd_d[2] = cnd_q[1];
      vld_d[1] = vld_q[0];
      dst_d[1] = dst_q[0];
      cnd_d[1] = cnd_q[0];
      vld_d[0] = {acc1, acc0};
      dst_d[0] = {p1_b_in[7:0], p0_b_in[7:0]};
      cnd_d[0] = {p1_cond_in, p0_cond_in};
      if (fire) begin
        vld_d = '0;
      end
    end
  end

  // Next-state for the drain FSM and the saturating taken-branch counter.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    taken_d     = taken_q;
    if (advance) begin
      if (fire) begin
        if (DRAIN_CYCLES > 0) begin
          state_d     = DRAIN;
          drain_cnt_d = DW'(DRAIN_CYCLES);
        end
        if (taken_q != {CNT_W{1'b1}}) begin
          taken_d = taken_q + CNT_W'(1);
        end
      end else if (state_q == DRAIN) begin
        drain_cnt_d = drain_cnt_q - DW'(1);
        if (drain_cnt_q == DW'(1)) begin
          state_d = IDLE;
        end
      end
    end
    draining_d = (state_d == DRAIN);
  end

  // Pipeline slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dst_q <= '0;
      cnd_q <= '0;
    end else begin
      vld_q <= vld_d;
      dst_q <= dst_d;
      cnd_q <= cnd_d;
    end
  end

  // FSM state, drain counter, registered draining flag and taken counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      draining_q  <= 1'b0;
      taken_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      draining_q  <= draining_d;
      taken_q     <= taken_d;
    end
  end

  assign draining    = draining_q;
  assign taken_count = taken_q;

endmodule
